// File: rtl/ascii_burst_send.sv
// ascii_burst_send
// ----------------
// Sends ASCII characters to a UART transmitter when a debounced button is
// pressed. In single mode (mode=0) each press sends one character; in burst
// mode (mode=1) each press sends BURST_LEN consecutive characters. The
// character register counts FIRST_CHAR..LAST_CHAR and wraps. The register
// persists across presses, so each press continues where the last one stopped.
//
// Handshake with the transmitter: start is a one-cycle request. The
// transmitter acknowledges by raising tx_busy and completes by dropping it.
// If tx_busy has not risen within ACK_TIMEOUT cycles, the request is
// abandoned. err pulses, and the character is not advanced.
//
// Ports:
//   clk      - system clock, rising edge
//   reset    - synchronous, active-low reset
//   btn      - debounced trigger level (rising edge triggers)
//   mode     - 0 = single character, 1 = burst; sampled at trigger
//   tx_busy  - transmitter busy, from accept until end of stop bit
//   start    - one-cycle transmit request (registered)
//   tx_data  - character to transmit (current character register)
//   busy     - state machine is not idle
//   done     - one-cycle pulse when a send sequence completes normally
//   err      - one-cycle pulse when the acknowledge timeout expires
module ascii_burst_send #(
    parameter logic [7:0] FIRST_CHAR  = 8'h30,
    parameter logic [7:0] LAST_CHAR   = 8'h39,
    parameter int         BURST_LEN   = 10,
    parameter int         ACK_TIMEOUT = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       btn,
    input  logic       mode,
    input  logic       tx_busy,
    output logic       start,
    output logic [7:0] tx_data,
    output logic       busy,
    output logic       done,
    output logic       err
);

    localparam int TW = $clog2(ACK_TIMEOUT + 1);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        SEND      = 2'd1,
        WAIT_ACK  = 2'd2,
        WAIT_DONE = 2'd3
    } state_t;

    state_t        state, state_n;
    logic          btn_q;
    logic          trigger;
    logic [7:0]    char_q, char_n;
    logic [7:0]    rem_q, rem_n;
    logic [TW-1:0] tmo_q, tmo_n;
    logic          done_n, err_n;

    // A level held high only produces one trigger, because btn_q follows it.
    assign trigger = btn & ~btn_q;
    assign tx_data = char_q;
    assign busy    = (state != IDLE);

    always_comb begin
        state_n = state;
        char_n  = char_q;
        rem_n   = rem_q;
        tmo_n   = tmo_q;
        done_n  = 1'b0;
        err_n   = 1'b0;
        case (state)
            IDLE: begin
                if (trigger) begin
                    state_n = SEND;
                    rem_n   = mode ? 8'(BURST_LEN) : 8'd1;
                    tmo_n   = '0;
                end
            end
            SEND: begin
                state_n = WAIT_ACK;
            end
            WAIT_ACK: begin
                // tx_busy already high on entry counts as the acknowledge.
                if (tx_busy) begin
                    state_n = WAIT_DONE;
                end else begin
                    tmo_n = tmo_q + TW'(1);
                    if (tmo_n == TW'(ACK_TIMEOUT)) begin
                        err_n   = 1'b1;
                        state_n = IDLE;
                    end
                end
            end
            WAIT_DONE: begin
                if (!tx_busy) begin
                    char_n = (char_q == LAST_CHAR) ? FIRST_CHAR : char_q + 8'd1;
                    rem_n  = rem_q - 8'd1;
                    if (rem_n != 8'd0) begin
                        state_n = SEND;
                        tmo_n   = '0;
                    end else begin
                        state_n = IDLE;
                        done_n  = 1'b1;
                    end
                end
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state  <= IDLE;
            btn_q  <= 1'b0;
            char_q <= FIRST_CHAR;
            rem_q  <= 8'd0;
            tmo_q  <= '0;
            start  <= 1'b0;
            done   <= 1'b0;
            err    <= 1'b0;
        end else begin
            state  <= state_n;
            btn_q  <= btn;
            char_q <= char_n;
            rem_q  <= rem_n;
            tmo_q  <= tmo_n;
            // start is high exactly for the cycle spent in SEND.
            start  <= (state_n == SEND);
            done   <= done_n;
            err    <= err_n;
        end
    end

endmodule
